sync_fifo_fwft: RTL and testbench



---
 rtl/sync_fifo_fwft.sv | 101 ++++++++++
 tb/tb_sync_fifo_fwft.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - parametrised single-clock FIFO with first-word-fall-through or registered read
// Flags are decoded from the count register; acceptance uses this cycle's registered full/empty.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]      count_nxt;
  logic                  wr_acc, rd_acc, rd_valid_q;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // flush drops same-cycle requests, so they are never accepted
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (wr_acc) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
    if (rd_acc) rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_data    <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      rd_valid_q <= rd_acc;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
      if (FWFT != 0) begin
        // Preload the next head; bypass the write when it lands on the new head slot.
        if (count_nxt != '0)
          rd_data <= (wr_acc && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
      end else if (rd_acc) begin
        rd_data <= mem[rd_ptr];
      end
    end
  end

  assign rd_valid = (FWFT != 0) ? !empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb/tb_sync_fifo_fwft.sv - self-checking bench for sync_fifo_fwft against a queue reference model
// Instance A: DEPTH=4 FWFT=1 AF=2 AE=1; instance B: DEPTH=5 FWFT=0 AF=3 AE=2; both see the same stimulus.
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst, flush, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] a_rd_data, b_rd_data;
  logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] a_count, b_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa [$];
  logic [7:0] qb [$];
  bit         ovf_m [2];
  bit         unf_m [2];
  bit         vld_m [2];
  logic [7:0] hold_m [2];

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AFULL_THRESH(2), .AEMPTY_THRESH(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_fwft #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%s] got %0h exp %0h", tag, (k == 0) ? "A" : "B", got, exp);
    end
  endtask

  task automatic model(input int k);
    logic [7:0] q [$];
    int n, d;
    if (k == 0) q = qa; else q = qb;
    d = (k == 0) ? 4 : 5;
    n = q.size();
    if (flush) begin
      q.delete();
      ovf_m[k] = 0; unf_m[k] = 0; vld_m[k] = 0; hold_m[k] = 8'h00;
    end else begin
      if (wr_en && n == d) ovf_m[k] = 1;
      if (rd_en && n == 0) unf_m[k] = 1;
      vld_m[k] = 0;
      if (rd_en && n > 0) begin
        hold_m[k] = q.pop_front();
        vld_m[k]  = 1;
      end
      if (wr_en && n < d) q.push_back(wr_data);
    end
    if (k == 0) qa = q; else qb = q;
  endtask

  task automatic check_model(input int k);
    logic [7:0] q [$];
    logic [7:0] rdd;
    logic [2:0] cnt;
    logic       rv, fu, em, af, ae, ov, un;
    int         sz, d, afth, aeth;
    if (k == 0) begin
      q = qa; rdd = a_rd_data; cnt = a_count; rv = a_rd_valid; fu = a_full; em = a_empty;
      af = a_af; ae = a_ae; ov = a_ovf; un = a_unf; d = 4; afth = 2; aeth = 1;
    end else begin
      q = qb; rdd = b_rd_data; cnt = b_count; rv = b_rd_valid; fu = b_full; em = b_empty;
      af = b_af; ae = b_ae; ov = b_ovf; un = b_unf; d = 5; afth = 3; aeth = 2;
    end
    sz = q.size();
    chk("count", k, 32'(cnt), 32'(sz));
    chk("full", k, 32'(fu), 32'(sz == d));
    chk("empty", k, 32'(em), 32'(sz == 0));
    chk("almost_full", k, 32'(af), 32'(sz >= afth));
    chk("almost_empty", k, 32'(ae), 32'(sz <= aeth));
    chk("overflow", k, 32'(ov), 32'(ovf_m[k]));
    chk("underflow", k, 32'(un), 32'(unf_m[k]));
    if (k == 0) begin
      chk("rd_valid", k, 32'(rv), 32'(sz > 0));
      if (sz > 0) chk("rd_data_head", k, 32'(rdd), 32'(q[0]));
    end else begin
      chk("rd_valid", k, 32'(rv), 32'(vld_m[k]));
      chk("rd_data", k, 32'(rdd), 32'(hold_m[k]));
    end
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    wr_en = w; wr_data = d; rd_en = r; flush = f;
    @(posedge clk);
    #1;
    model(0); model(1);
    check_model(0); check_model(1);
  endtask

  initial begin
    int wp, rp;
    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    for (int k = 0; k < 2; k++) begin
      ovf_m[k] = 0; unf_m[k] = 0; vld_m[k] = 0; hold_m[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_model(0); check_model(1);
    chk("reset_rd_data", 0, 32'(a_rd_data), 32'h0);
    chk("reset_rd_data", 1, 32'(b_rd_data), 32'h0);

    // FWFT ordering on the DEPTH=4 instance
    step(1, 8'h11, 0, 0);
    chk("fwft_first_valid", 0, 32'(a_rd_valid), 32'h1);
    chk("fwft_first_data", 0, 32'(a_rd_data), 32'h11);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 0, 0);
    chk("plan_count3", 0, 32'(a_count), 32'h3);
    chk("plan_afull", 0, 32'(a_af), 32'h1);
    repeat (3) step(0, 8'h00, 1, 0);
    chk("plan_drained", 0, 32'(a_empty), 32'h1);

    // DEPTH=5 registered-read across the pointer wrap
    for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 0, 0);
    chk("b_full5", 1, 32'(b_full), 32'h1);
    repeat (2) step(0, 8'h00, 1, 0);
    for (int i = 0; i < 2; i++) step(1, 8'h50 + 8'(i), 0, 0);
    repeat (5) step(0, 8'h00, 1, 0);
    chk("b_final_count", 1, 32'(b_count), 32'h0);
    step(0, 8'h00, 0, 1);

    // Full with simultaneous write and read
    for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 0);
    step(1, 8'hEE, 1, 0);
    chk("full_rw_count", 1, 32'(b_count), 32'h4);
    chk("full_rw_ovf", 1, 32'(b_ovf), 32'h1);
    chk("full_rw_count", 0, 32'(a_count), 32'h3);
    repeat (2) step(0, 8'h00, 0, 0);
    chk("ovf_sticky", 1, 32'(b_ovf), 32'h1);
    step(0, 8'h00, 0, 1);
    chk("ovf_flushed", 1, 32'(b_ovf), 32'h0);

    // Empty with simultaneous write and read
    step(1, 8'h77, 1, 0);
    chk("empty_rw_count", 0, 32'(a_count), 32'h1);
    chk("empty_rw_unf", 0, 32'(a_unf), 32'h1);
    chk("empty_rw_data", 0, 32'(a_rd_data), 32'h77);

    // Flush overrides same-cycle requests
    step(1, 8'h81, 0, 0);
    step(1, 8'h82, 0, 0);
    step(1, 8'h83, 1, 1);
    chk("flush_rd_data", 0, 32'(a_rd_data), 32'h0);
    chk("flush_rd_data", 1, 32'(b_rd_data), 32'h0);
    chk("flush_unf", 0, 32'(a_unf), 32'h0);
    step(1, 8'h91, 0, 0);
    chk("post_flush_head", 0, 32'(a_rd_data), 32'h91);

    // Asynchronous reset between edges with three words stored
    step(1, 8'h92, 0, 0);
    step(1, 8'h93, 0, 0);
    chk("pre_reset_count", 0, 32'(a_count), 32'h3);
    wr_en = 1'b0; rd_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("async_count", 0, 32'(a_count), 32'h0);
    chk("async_empty", 0, 32'(a_empty), 32'h1);
    chk("async_valid", 0, 32'(a_rd_valid), 32'h0);
    chk("async_count", 1, 32'(b_count), 32'h0);
    chk("async_rd_data", 0, 32'(a_rd_data), 32'h0);
    qa.delete(); qb.delete();
    for (int k = 0; k < 2; k++) begin
      ovf_m[k] = 0; unf_m[k] = 0; vld_m[k] = 0; hold_m[k] = 8'h00;
    end
    #1 rst = 1'b0;
    step(1, 8'hA5, 0, 0);
    chk("after_reset_push", 0, 32'(a_rd_data), 32'hA5);
    step(0, 8'h00, 1, 0);
    chk("after_reset_pop", 1, 32'(b_rd_data), 32'hA5);
    chk("after_reset_pulse", 1, 32'(b_rd_valid), 32'h1);

    // Randomized traffic with alternating fill/drain bias and rare flushes
    for (int c = 0; c < 600; c++) begin
      wp = ((c / 50) % 2 == 0) ? 70 : 30;
      rp = 100 - wp;
      step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
           $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
